// File: rtl/dl_seq_pkg.sv
// Shared types for the ROM download sequencer.
// States, FIFO entry layout and default widths.
package dl_seq_pkg;

  localparam int DL_ADDR_W       = 19;
  localparam int DL_REGION_SHIFT = 14;
  localparam int DL_REGION_W     = DL_ADDR_W - DL_REGION_SHIFT;
  localparam int DL_DATA_W       = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    HOLD,
    RUN
  } state_t;

  typedef struct packed {
    logic [DL_ADDR_W-1:0] addr;
    logic [DL_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO.
// A push into a full FIFO is taken when a pop happens the same cycle.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dl_sequencer.sv
// ROM download sequencer: buffers ioctl writes, replays them to the
// core over valid/ready and owns the core reset.
module dl_sequencer
  import dl_seq_pkg::*;
#(
  parameter int ADDR_W       = DL_ADDR_W,
  parameter int REGION_SHIFT = DL_REGION_SHIFT,
  parameter int FIFO_DEPTH   = 4,
  parameter int HOLD_CYCLES  = 1024
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     ioctl_download,
  input  logic                     ioctl_wr,
  input  logic [ADDR_W-1:0]        ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [7:0]               mem_data,
  output logic [ADDR_W-REGION_SHIFT-1:0] mem_region,
  output logic                     core_reset,
  output logic                     busy,
  output logic                     overflow,
  output logic [ADDR_W:0]          byte_count,
  output logic [7:0]               checksum
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [ADDR_W:0]   BC_ONE    = (ADDR_W+1)'(1);

  state_t            state;
  state_t            state_nx;
  logic              dl_prev;
  logic              rise;
  logic              fall;
  logic [HOLD_W-1:0] hold_cnt;
  entry_t            wr_e;
  entry_t            head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              load;
  logic              pop;
  logic              push_req;
  logic              push_ok;

  assign rise     = ioctl_download & ~dl_prev;
  assign fall     = ~ioctl_download & dl_prev;
  assign load     = ~mem_valid | mem_ready;
  assign pop      = load & ~fifo_empty;
  assign push_req = ioctl_wr & ((state == LOAD) || (state == DRAIN));
  assign push_ok  = push_req & (~fifo_full | pop);
  assign busy     = (state != RUN);

  assign wr_e.addr = ioctl_addr;
  assign wr_e.data = ioctl_dout;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk   (clk_sys),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (wr_e),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, RUN: if (rise) state_nx = LOAD;
      LOAD:      if (fall) state_nx = DRAIN;
      DRAIN: begin
        if (rise) state_nx = LOAD;
        else if (fifo_empty && !mem_valid) state_nx = HOLD;
      end
      HOLD: begin
        if (rise) state_nx = LOAD;
        else if (hold_cnt == HOLD_LAST) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // dl_prev tracks the pin even in reset so a level still high
  // afterwards is not mistaken for a new download.
  always_ff @(posedge clk_sys) begin
    dl_prev <= ioctl_download;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_region <= '0;
      core_reset <= 1'b1;
      overflow   <= 1'b0;
      byte_count <= '0;
      checksum   <= '0;
    end else begin
      state      <= state_nx;
      core_reset <= (state_nx != RUN);
      hold_cnt   <= (state == HOLD) ? hold_cnt + HOLD_ONE : '0;
      if (load) begin
        mem_valid <= ~fifo_empty;
        if (!fifo_empty) begin
          mem_addr   <= head.addr;
          mem_data   <= head.data;
          mem_region <= head.addr[ADDR_W-1:REGION_SHIFT];
        end
      end
      if (rise) begin
        overflow   <= push_req & ~push_ok;
        byte_count <= push_ok ? BC_ONE : '0;
        checksum   <= push_ok ? ioctl_dout : '0;
      end else begin
        if (push_req && !push_ok) overflow <= 1'b1;
        if (push_ok) begin
          if (byte_count != '1) byte_count <= byte_count + BC_ONE;
          checksum <= checksum + ioctl_dout;
        end
      end
    end
  end

endmodule
